// File: rtl/qspi_cmd_sequencer_pkg.sv
// qspi_pkg
// Shared types and defaults for the QSPI command/address sequencer.
//   seq_state_t    : sequencer state encoding
//   BITS_PER_BYTE  : bits shifted per byte on IO0
//   DEF_CLK_DIV    : default clk cycles per sck half-period
//   DEF_ADDR_BYTES : default number of address bytes
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    DUMMY    = 3'd3,
    HANDOFF  = 3'd4,
    CS_HOLD  = 3'd5,
    DESELECT = 3'd6
  } seq_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_ADDR_BYTES = 3;

endpackage

// File: rtl/qspi_cmd_sequencer_sck_div.sv
// qspi_sck_div
// Half-period divider and sck generator.
//   clk, rst : system clock, async active-high reset
//   en       : count div_cnt 0..CLK_DIV-1
//   tog_en   : toggle sck on each tick
//   clr      : clear div_cnt and force sck low (has priority over en)
//   tick     : high in the terminal-count cycle of div_cnt
//   sck      : serial clock, idles low
module qspi_sck_div
  import qspi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tog_en,
  input  logic clr,
  output logic tick,
  output logic sck
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (en) begin
      if (tick) begin
        // wrapping on tick means every tick-driven state change enters with div_cnt=0
        div_cnt <= '0;
        if (tog_en) sck <= ~sck;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/qspi_cmd_sequencer.sv
// qspi_cmd_sequencer
// Drives cs_n/sck and the IO0 shift register through the command, address
// and dummy phases of a QSPI transaction, then hands off to the data engine.
//   clk, rst       : system clock, async active-high reset
//   start          : request pulse, taken only while ready
//   cmd, addr      : instruction byte and address (MSB byte first)
//   addr_en        : send ADDR_BYTES address bytes after cmd
//   dummy_cycles   : full sck periods after the last byte
//   cs_release     : data engine finished (honoured in HANDOFF only)
//   abort          : immediate termination back to IDLE
//   ready/busy     : idle indication and its complement
//   done           : one-cycle pulse at entry to HANDOFF
//   sr_data/sr_load/sr_shift_en : shift register controls
//   sck, cs_n      : serial clock (mode 0) and chip select
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | ready, cs_n high, waiting for start
// CS_SETUP | cs_n low, cmd loaded, sck held low for CLK_DIV cycles
// SHIFT    | toggling sck, shifting cmd then address bytes
// DUMMY    | toggling sck for dummy_cycles periods, no strobes
// HANDOFF  | done pulsed, cs_n low, waiting for cs_release
// CS_HOLD  | cs_n still low for CLK_DIV cycles
// DESELECT | cs_n high for CLK_DIV cycles before ready
module qspi_cmd_sequencer
  import qspi_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int ADDR_BYTES = DEF_ADDR_BYTES,
  parameter int DUMMY_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              cmd,
  input  logic [8*ADDR_BYTES-1:0] addr,
  input  logic                    addr_en,
  input  logic [DUMMY_W-1:0]      dummy_cycles,
  input  logic                    cs_release,
  input  logic                    abort,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              sr_data,
  output logic                    sr_load,
  output logic                    sr_shift_en,
  output logic                    sck,
  output logic                    cs_n
);

  localparam int AW = 8 * ADDR_BYTES;

  seq_state_t         state;
  logic [2:0]         bit_cnt;
  logic [2:0]         bytes_left;
  logic [DUMMY_W-1:0] dummy_left;
  logic [AW-1:0]      addr_q;

  logic div_en;
  logic div_tog;
  logic div_clr;
  logic tick;
  logic fall_tick;

  assign div_en  = (state == CS_SETUP) || (state == SHIFT) || (state == DUMMY) ||
                   (state == CS_HOLD)  || (state == DESELECT);
  assign div_tog = (state == SHIFT) || (state == DUMMY);
  // idle/handoff hold the divider cleared so every timed state starts from zero
  assign div_clr = abort || !div_en;

  // a tick while sck is high is the falling edge about to happen
  assign fall_tick = tick && sck;

  assign busy = ~ready;

  qspi_sck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_div (
    .clk    (clk),
    .rst    (rst),
    .en     (div_en),
    .tog_en (div_tog),
    .clr    (div_clr),
    .tick   (tick),
    .sck    (sck)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      sr_data     <= 8'h00;
      sr_load     <= 1'b0;
      sr_shift_en <= 1'b0;
      cs_n        <= 1'b1;
      bit_cnt     <= 3'd0;
      bytes_left  <= 3'd0;
      dummy_left  <= '0;
      addr_q      <= '0;
    end else begin
      done        <= 1'b0;
      sr_load     <= 1'b0;
      sr_shift_en <= 1'b0;

      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        ready   <= 1'b1;
        cs_n    <= 1'b1;
        sr_data <= 8'h00;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start && ready) begin
              addr_q     <= addr;
              bytes_left <= addr_en ? 3'(ADDR_BYTES) : 3'd0;
              dummy_left <= dummy_cycles;
              bit_cnt    <= 3'd0;
              sr_data    <= cmd;
              sr_load    <= 1'b1;
              cs_n       <= 1'b0;
              ready      <= 1'b0;
              state      <= CS_SETUP;
            end
          end

          CS_SETUP: begin
            if (tick) state <= SHIFT;
          end

          SHIFT: begin
            if (fall_tick) begin
              if (bit_cnt != 3'(BITS_PER_BYTE - 1)) begin
                sr_shift_en <= 1'b1;
                bit_cnt     <= bit_cnt + 3'd1;
              end else begin
                bit_cnt <= 3'd0;
                sr_load <= 1'b1;
                if (bytes_left != 3'd0) begin
                  sr_data    <= addr_q[AW-1 -: 8];
                  addr_q     <= addr_q << 8;
                  bytes_left <= bytes_left - 3'd1;
                end else begin
                  // park IO0 low for the dummy/handoff phases
                  sr_data <= 8'h00;
                  if (dummy_left != '0) begin
                    state <= DUMMY;
                  end else begin
                    state <= HANDOFF;
                    done  <= 1'b1;
                  end
                end
              end
            end
          end

          DUMMY: begin
            if (fall_tick) begin
              dummy_left <= dummy_left - DUMMY_W'(1);
              if (dummy_left == DUMMY_W'(1)) begin
                state <= HANDOFF;
                done  <= 1'b1;
              end
            end
          end

          HANDOFF: begin
            if (cs_release) state <= CS_HOLD;
          end

          CS_HOLD: begin
            if (tick) begin
              cs_n  <= 1'b1;
              state <= DESELECT;
            end
          end

          DESELECT: begin
            if (tick) begin
              ready <= 1'b1;
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
            ready <= 1'b1;
            cs_n  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// tb_qspi_cmd_sequencer
// Two sequencers (CLK_DIV=2 and CLK_DIV=1) share inputs; sel picks which one
// receives start/cs_release/abort and which one the monitor observes.
module tb_qspi_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, addr_en, cs_release, abort, sel;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [3:0]  dummy_cycles;

  logic a_start, a_rel, a_abort, b_start, b_rel, b_abort;
  logic a_ready, a_busy, a_done, a_load, a_shift, a_sck, a_cs_n;
  logic b_ready, b_busy, b_done, b_load, b_shift, b_sck, b_cs_n;
  logic [7:0] a_data, b_data;

  logic m_ready, m_busy, m_done, m_load, m_shift, m_sck, m_cs_n;
  logic [7:0] m_data;

  assign a_start = start & ~sel;
  assign a_rel   = cs_release & ~sel;
  assign a_abort = abort & ~sel;
  assign b_start = start & sel;
  assign b_rel   = cs_release & sel;
  assign b_abort = abort & sel;

  assign m_ready = sel ? b_ready : a_ready;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_load  = sel ? b_load  : a_load;
  assign m_shift = sel ? b_shift : a_shift;
  assign m_sck   = sel ? b_sck   : a_sck;
  assign m_cs_n  = sel ? b_cs_n  : a_cs_n;
  assign m_data  = sel ? b_data  : a_data;

  always #5 clk = ~clk;

  qspi_cmd_sequencer #(.CLK_DIV(2), .ADDR_BYTES(3), .DUMMY_W(4)) u_dut_div2 (
    .clk(clk), .rst(rst), .start(a_start), .cmd(cmd), .addr(addr), .addr_en(addr_en),
    .dummy_cycles(dummy_cycles), .cs_release(a_rel), .abort(a_abort),
    .ready(a_ready), .busy(a_busy), .done(a_done), .sr_data(a_data),
    .sr_load(a_load), .sr_shift_en(a_shift), .sck(a_sck), .cs_n(a_cs_n));

  qspi_cmd_sequencer #(.CLK_DIV(1), .ADDR_BYTES(3), .DUMMY_W(4)) u_dut_div1 (
    .clk(clk), .rst(rst), .start(b_start), .cmd(cmd), .addr(addr), .addr_en(addr_en),
    .dummy_cycles(dummy_cycles), .cs_release(b_rel), .abort(b_abort),
    .ready(b_ready), .busy(b_busy), .done(b_done), .sr_data(b_data),
    .sr_load(b_load), .sr_shift_en(b_shift), .sck(b_sck), .cs_n(b_cs_n));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor: shift register model, sck rise capture, strobe bookkeeping
  int   div = 2;
  logic in_txn = 1'b0;
  logic [7:0] sr_m = 8'h00;
  logic sck_prev = 1'b0;
  int   hi_run = 0;
  int   n_rise = 0, n_load = 0, n_shift = 0, n_done = 0, n_ovl = 0, n_cs_hi = 0, n_badhi = 0;
  logic bits[$];

  always @(negedge clk) begin
    if (m_sck && !sck_prev) begin
      bits.push_back(sr_m[7]);
      n_rise++;
    end
    if (m_sck) hi_run++;
    else begin
      if (sck_prev && hi_run != div) n_badhi++;
      hi_run = 0;
    end
    if (m_load && m_shift) n_ovl++;
    if (m_load) n_load++;
    if (m_shift) n_shift++;
    if (m_done) n_done++;
    if (in_txn && m_cs_n) n_cs_hi++;
    sck_prev = m_sck;
    if (m_load) sr_m = m_data;
    else if (m_shift) sr_m = {sr_m[6:0], 1'b0};
  end

  // sck rises (cmd/addr bits then dummy periods) fall every 2*dv cycles,
  // the first one dv cycles into SHIFT, which starts at cycle dv+1
  function automatic int rises_upto(input int k, input int dv, input int total);
    int r = 0;
    for (int j = 0; j < total; j++)
      if ((dv + 1) + dv + 2 * dv * j <= k) r++;
    return r;
  endfunction

  task automatic run_txn(input logic [7:0] c, input logic [23:0] a, input logic ae,
                         input logic [3:0] d, input int rel, input int ab_at,
                         input bit use_rst, input bit dsel, input bit desel_start);
    int nb, exp_done, k, j, tmo, bb;
    int b_rise, b_load, b_shift, b_done, b_ovl, b_cshi, b_badhi, b_bits;
    logic [7:0] exp_b [4];
    logic [7:0] got;
    bit hit;

    sel = dsel;
    div = dsel ? 1 : 2;
    tmo = 0;
    while (!m_ready && tmo < 200) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("ready_before_start", m_ready, 1);

    nb = 1 + (ae ? 3 : 0);
    exp_b[0] = c;
    for (int i = 0; i < 3; i++) exp_b[1 + i] = 8'(a >> (16 - 8 * i));
    exp_done = div * (1 + 16 * nb + 2 * d) + 1;

    b_rise = n_rise; b_load = n_load; b_shift = n_shift; b_done = n_done;
    b_ovl = n_ovl; b_cshi = n_cs_hi; b_badhi = n_badhi; b_bits = bits.size();

    cmd = c; addr = a; addr_en = ae; dummy_cycles = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_txn = 1'b1;
    chk("c1_cs_n", m_cs_n, 0);
    chk("c1_sr_load", m_load, 1);
    chk("c1_sr_data", m_data, c);
    chk("c1_busy", m_busy, 1);
    // later input changes and a start while busy must have no effect
    cmd = ~c; addr = ~a; addr_en = ~ae; dummy_cycles = d + 4'd3;

    k = 1;
    hit = 0;
    while (!m_done && k < 3000) begin
      start = (k == 3);
      if (k == ab_at) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;

    if (hit) begin
      in_txn = 1'b0;
      if (use_rst) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", m_ready, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_sr_load", m_load, 0);
        chk("rst_sr_shift", m_shift, 0);
        chk("rst_sr_data", m_data, 0);
        chk("rst_sck", m_sck, 0);
        chk("rst_cs_n", m_cs_n, 1);
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_cs_n", m_cs_n, 1);
        chk("abort_sck", m_sck, 0);
        chk("abort_ready", m_ready, 1);
        chk("abort_done", m_done, 0);
        chk("abort_rises", n_rise - b_rise, rises_upto(ab_at, div, 8 * nb + d));
      end
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
      end
      chk("abort_no_done", n_done - b_done, 0);
      chk("abort_idle_cs_n", m_cs_n, 1);
      chk("abort_idle_ready", m_ready, 1);
      return;
    end

    chk("done_cycle", k, exp_done);
    if (!m_done) begin
      in_txn = 1'b0;
      return;
    end

    for (int i = 0; i < rel; i++) begin
      @(posedge clk); #1;
    end
    chk("handoff_cs_n", m_cs_n, 0);
    chk("handoff_sck", m_sck, 0);
    cs_release = 1'b1;
    in_txn = 1'b0;
    @(posedge clk); #1;
    cs_release = 1'b0;
    j = 1;
    while (m_cs_n == 1'b0 && j < 50) begin
      @(posedge clk); #1;
      j++;
    end
    chk("cs_hold_cycles", j, div + 1);
    start = desel_start;
    j = 0;
    while (!m_ready && j < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      j++;
    end
    start = 1'b0;
    chk("deselect_cycles", j, div);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_after_cs_n", m_cs_n, 1);
    chk("idle_after_ready", m_ready, 1);

    chk("done_once", n_done - b_done, 1);
    chk("no_overlap", n_ovl - b_ovl, 0);
    chk("cs_low_whole_txn", n_cs_hi - b_cshi, 0);
    chk("sck_rises", n_rise - b_rise, 8 * nb + d);
    chk("shift_strobes", n_shift - b_shift, 7 * nb);
    chk("load_strobes", n_load - b_load, nb + 1);
    chk("sck_high_width", n_badhi - b_badhi, 0);
    if (bits.size() >= b_bits + 8 * nb) begin
      for (int bi = 0; bi < nb; bi++) begin
        got = 8'h00;
        for (int i = 0; i < 8; i++) got = {got[6:0], bits[b_bits + 8 * bi + i]};
        chk($sformatf("byte%0d", bi), got, exp_b[bi]);
      end
    end else begin
      chk("bits_captured", bits.size() - b_bits, 8 * nb);
    end
    bb = 0;
    for (int i = b_bits + 8 * nb; i < bits.size(); i++) if (bits[i]) bb++;
    chk("dummy_io0_low", bb, 0);
  endtask

  initial begin
    int dv, ed, nb;
    logic [3:0] d;
    logic ae;
    rst = 1'b1; start = 1'b0; addr_en = 1'b0; cs_release = 1'b0; abort = 1'b0;
    sel = 1'b0; cmd = 8'h00; addr = 24'h0; dummy_cycles = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", m_ready, 1);
    chk("reset_busy", m_busy, 0);
    chk("reset_cs_n", m_cs_n, 1);
    chk("reset_sck", m_sck, 0);
    chk("reset_done", m_done, 0);
    chk("reset_sr_data", m_data, 0);
    chk("reset_div1_ready", b_ready, 1);

    run_txn(8'h03, 24'h123456, 1'b1, 4'd0, 2, 0, 0, 0, 0);
    run_txn(8'h9F, 24'h000000, 1'b0, 4'd8, 3, 0, 0, 0, 0);
    run_txn(8'hA5, 24'hC0FFEE, 1'b1, 4'd2, 5, 0, 0, 0, 1);
    // abort during the high phase of bit 4 of byte 2
    run_txn(8'h0B, 24'hABCDEF, 1'b1, 4'd0, 0, 3 + 32 + 16 + 2, 0, 0, 0);
    run_txn(8'h6B, 24'h00FF80, 1'b1, 4'd1, 0, 0, 0, 0, 0);
    run_txn(8'h5A, 24'h112233, 1'b1, 4'd0, 1, 20, 1, 0, 0);
    run_txn(8'hEB, 24'h8001FE, 1'b1, 4'd3, 4, 0, 0, 1, 1);
    run_txn(8'h5A, 24'h445566, 1'b0, 4'd0, 0, 0, 0, 1, 0);

    for (int t = 0; t < 16; t++) begin
      dv = ($urandom_range(0, 1) == 1) ? 1 : 2;
      ae = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      nb = 1 + (ae ? 3 : 0);
      ed = dv * (1 + 16 * nb + 2 * d) + 1;
      run_txn(8'($urandom), 24'($urandom), ae, d, $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0) ? $urandom_range(4, ed - 1) : 0,
              0, (dv == 1), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
